// File: rtl/noc_pkg.sv
// Shared mesh definitions: flit type encodings and flit field offsets.
package noc_pkg;
  localparam logic [1:0] FLIT_HEAD    = 2'b00;
  localparam logic [1:0] FLIT_BODY    = 2'b01;
  localparam logic [1:0] FLIT_TAIL    = 2'b10;
  localparam logic [1:0] FLIT_ILLEGAL = 2'b11;

  localparam int COORD_W  = 3;
  localparam int TYPE_W   = 2;
  localparam int ROW_LSB  = 5;
  localparam int COL_LSB  = 2;
  localparam int TYPE_LSB = 0;
endpackage

// File: rtl/flit_fifo.sv
// Generic flit FIFO with wrap-bit pointers and a combinational head read.
module flit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             w_wr, w_rd;

  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign count = r_wr_ptr - r_rd_ptr;
  // Writes are refused when full even if a read happens in the same cycle.
  assign w_wr  = wr_en && !full;
  assign w_rd  = rd_en && !empty;

  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/local_ejection_unit.sv
// Local-port sink: buffers ejected flits, drives ON/OFF backpressure,
// checks packet framing and destination, and counts packets/flits.
module local_ejection_unit
  import noc_pkg::*;
#(
  parameter int         LINK_WIDTHS  = 8,
  parameter int         BUFFER_DEPTH = 4,
  parameter logic [2:0] MY_ROW       = 3'd0,
  parameter logic [2:0] MY_COL       = 3'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINK_WIDTHS-1:0] in_flit,
  input  logic                   in_valid,
  output logic                   ON_OFF,
  output logic [LINK_WIDTHS-1:0] out_flit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            pkt_count,
  output logic [15:0]            flit_count,
  output logic                   err_misroute,
  output logic                   err_framing,
  output logic                   err_overflow
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam logic [AW:0] ON_THRESH = (AW+1)'(BUFFER_DEPTH - 2);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_on_off;
  logic [15:0]         r_pkt_cnt, r_flit_cnt;
  logic                r_err_mis, r_err_frm, r_err_ovf;
  logic                w_full, w_empty, w_wr, w_rd;
  logic [AW:0]         w_count, w_cnt_nxt;
  logic [TYPE_W-1:0]   w_type;
  logic                w_dest_ok;
  logic                w_set_mis, w_set_frm, w_tail_done;

  assign w_wr      = in_valid && !w_full;
  assign w_rd      = !w_empty && out_ready;
  assign w_cnt_nxt = w_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
  assign w_type    = in_flit[TYPE_LSB +: TYPE_W];
  assign w_dest_ok = (in_flit[ROW_LSB +: COORD_W] == MY_ROW) &&
                     (in_flit[COL_LSB +: COORD_W] == MY_COL);

  flit_fifo #(.WIDTH(LINK_WIDTHS), .DEPTH(BUFFER_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_flit),
    .rd_en   (out_ready),
    .rd_data (out_flit),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_set_mis   = 1'b0;
    w_set_frm   = 1'b0;
    w_tail_done = 1'b0;
    if (w_wr) begin
      case (w_type)
        FLIT_HEAD: begin
          // A head mid-packet is flagged but still starts the new packet.
          w_set_frm   = (r_state == IN_PKT);
          w_set_mis   = !w_dest_ok;
          w_state_nxt = IN_PKT;
        end
        FLIT_BODY: w_set_frm = (r_state == IDLE);
        FLIT_TAIL: begin
          if (r_state == IDLE) w_set_frm = 1'b1;
          else begin
            w_tail_done = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_set_frm = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_on_off   <= 1'b1;
      r_pkt_cnt  <= '0;
      r_flit_cnt <= '0;
      r_err_mis  <= 1'b0;
      r_err_frm  <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      // One free slot of slack absorbs the router's reaction cycle.
      r_on_off <= (w_cnt_nxt <= ON_THRESH);
      if (w_wr)        r_flit_cnt <= r_flit_cnt + 16'd1;
      if (w_tail_done) r_pkt_cnt  <= r_pkt_cnt + 16'd1;
      if (w_set_mis)   r_err_mis  <= 1'b1;
      if (w_set_frm)   r_err_frm  <= 1'b1;
      if (in_valid && w_full) r_err_ovf <= 1'b1;
    end
  end

  assign ON_OFF       = r_on_off;
  assign out_valid    = !w_empty;
  assign pkt_count    = r_pkt_cnt;
  assign flit_count   = r_flit_cnt;
  assign err_misroute = r_err_mis;
  assign err_framing  = r_err_frm;
  assign err_overflow = r_err_ovf;
endmodule

// File: tb/tb_local_ejection_unit.sv
// Scoreboard bench for local_ejection_unit: directed scenarios plus random streams.
module tb_local_ejection_unit;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [7:0]  in_flit, out_flit;
  logic        ON_OFF, out_valid;
  logic [15:0] pkt_count, flit_count;
  logic        err_misroute, err_framing, err_overflow;

  always #5 clk = ~clk;

  local_ejection_unit #(.LINK_WIDTHS(8), .BUFFER_DEPTH(D), .MY_ROW(3'd0), .MY_COL(3'd0)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .ON_OFF(ON_OFF),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_count(pkt_count), .flit_count(flit_count),
    .err_misroute(err_misroute), .err_framing(err_framing), .err_overflow(err_overflow)
  );

  int n_chk = 0, n_fail = 0;
  logic [7:0] sb[$];

  // Reference state: occupancy as a plain number, packet state as a flag.
  int m_occ, m_prev_occ, m_pkts, m_flits;
  bit m_inpkt, m_mis, m_frm, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every read handshake must present the oldest outstanding flit.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected nothing", out_flit);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (out_flit !== e) begin
          n_fail++;
          $display("FAIL out_order: got %0h expected %0h at %0t", out_flit, e, $time);
        end
      end
    end
  end

  task automatic model_accept(input logic [7:0] f);
    logic [1:0] t;
    t = f[1:0];
    sb.push_back(f);
    m_flits++;
    if (t == 2'b11) m_frm = 1;
    else if (t == 2'b00) begin
      if (m_inpkt) m_frm = 1;
      if (f[7:2] != 6'd0) m_mis = 1;
      m_inpkt = 1;
    end else if (t == 2'b01) begin
      if (!m_inpkt) m_frm = 1;
    end else begin
      if (!m_inpkt) m_frm = 1;
      else begin m_pkts++; m_inpkt = 0; end
    end
  endtask

  task automatic check_state();
    chk("out_valid", out_valid, m_occ > 0);
    chk("flit_count", flit_count, m_flits & 16'hffff);
    chk("pkt_count", pkt_count, m_pkts & 16'hffff);
    chk("err_misroute", err_misroute, m_mis);
    chk("err_framing", err_framing, m_frm);
    chk("err_overflow", err_overflow, m_ovf);
    if (m_occ >= D-1)                          chk("on_off_low", ON_OFF, 1'b0);
    else if (m_occ <= D-3)                     chk("on_off_high", ON_OFF, 1'b1);
    else if (m_prev_occ <= D-2)                chk("on_off_high", ON_OFF, 1'b1);
  endtask

  task automatic step(input bit v, input logic [7:0] f, input bit r);
    bit acc, rd;
    in_valid = v; in_flit = f; out_ready = r;
    acc = v && (m_occ < D);
    rd  = (m_occ > 0) && r;
    if (v && m_occ == D) m_ovf = 1;
    if (acc) model_accept(f);
    m_prev_occ = m_occ;
    m_occ = m_occ + int'(acc) - int'(rd);
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_flit = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    m_occ = 0; m_prev_occ = 0; m_pkts = 0; m_flits = 0;
    m_inpkt = 0; m_mis = 0; m_frm = 0; m_ovf = 0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_flit", out_flit, 8'h00);
    chk("rst_on_off", ON_OFF, 1'b1);
    chk("rst_pkt_count", pkt_count, 16'd0);
    chk("rst_flit_count", flit_count, 16'd0);
    chk("rst_errs", {err_misroute, err_framing, err_overflow}, 3'b000);
  endtask

  function automatic logic [7:0] mk(input logic [2:0] row, input logic [2:0] col, input logic [1:0] t);
    return {row, col, t};
  endfunction

  initial begin
    logic [7:0] pkt [4];
    bit gen_inpkt;
    pkt[0] = 8'b000_000_00; pkt[1] = 8'b001_000_01;
    pkt[2] = 8'b010_000_01; pkt[3] = 8'b100_000_10;

    // Legal packet streamed with the core always ready
    do_reset();
    step(1, pkt[0], 1);
    step(1, pkt[1], 1);
    chk("latency_1cyc", out_flit, pkt[1]);
    step(1, pkt[2], 1);
    step(1, pkt[3], 1);
    step(0, 8'h00, 1);
    chk("pkt1_count", pkt_count, 16'd1);
    chk("pkt1_flits", flit_count, 16'd4);

    // Misrouted head, rest of packet still counted
    step(1, 8'b011_011_00, 1);
    chk("misroute_set", err_misroute, 1'b1);
    step(1, 8'b011_011_01, 1);
    step(1, 8'b011_011_10, 1);
    step(0, 8'h00, 1);
    chk("misroute_pkts", pkt_count, 16'd2);

    // Orphan body in IDLE, then a legal packet
    do_reset();
    step(1, 8'b000_001_01, 1);
    chk("orphan_framing", err_framing, 1'b1);
    for (int i = 0; i < 4; i++) step(1, pkt[i], 1);
    step(0, 8'h00, 1);
    chk("orphan_pkts", pkt_count, 16'd1);

    // Fill with the core stalled, then one write too many
    do_reset();
    step(1, pkt[0], 0);
    step(1, pkt[1], 0);
    chk("on_after_2", ON_OFF, 1'b1);
    step(1, pkt[2], 0);
    chk("off_after_3", ON_OFF, 1'b0);
    step(1, pkt[2], 0);
    step(1, pkt[3], 0);
    chk("ovf_flag", err_overflow, 1'b1);
    chk("ovf_flits", flit_count, 16'd4);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1);

    // Reset mid-packet, then a clean packet
    do_reset();
    step(1, pkt[0], 0);
    step(1, pkt[1], 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, pkt[i], 1);
    step(0, 8'h00, 1);
    chk("post_rst_framing", err_framing, 1'b0);
    chk("post_rst_pkts", pkt_count, 16'd1);

    // Steady read/write at occupancy 2
    do_reset();
    step(1, mk(3'd0, 3'd0, 2'b00), 0);
    step(1, mk(3'd1, 3'd0, 2'b01), 0);
    for (int i = 0; i < 10; i++) begin
      step(1, mk(3'(i), 3'd0, 2'b01), 1);
      chk("steady_on", ON_OFF, 1'b1);
    end
    step(1, 8'b000_000_10, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);

    // Random traffic, router honouring ON_OFF, mostly well-formed packets
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      gen_inpkt = 0;
      for (int n = 0; n < 1500; n++) begin
        bit v;
        logic [1:0] t;
        logic [2:0] row, col;
        v = ($urandom_range(0, 99) < 70) && (phase == 1 || ON_OFF);
        if (!gen_inpkt) t = 2'b00;
        else t = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'b01;
        if ($urandom_range(0, 39) == 0) t = 2'($urandom);
        row = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
        col = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
        if (v && m_occ < D) begin
          if (t == 2'b00) gen_inpkt = 1;
          else if (t == 2'b10) gen_inpkt = 0;
        end
        step(v, mk(row, col, t), $urandom_range(0, 99) < 65);
      end
      for (int i = 0; i < 6; i++) step(0, 8'h00, 1);
      chk("drain_empty", sb.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
